// File: rtl/first_layer_rolin_par.sv
// First BNN layer, multi-lane rolled evaluation.
// A feature vector is latched on start. LANES neurons are then evaluated
// per cycle against fixed +/-1 weights and signed biases. The result is a
// HIDDEN_CNT-bit sign vector that is flagged valid once complete.
module first_layer_rolin_par #(
  parameter int FEAT_CNT   = 4,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 5,
  parameter int LANES      = 2,
  parameter int BIAS_BITS  = 8,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  WEIGHTS = '0,
  parameter logic [HIDDEN_CNT*BIAS_BITS-1:0] BIASES  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          busy,
  output logic [HIDDEN_CNT-1:0]         hidden,
  output logic                          hidden_valid
);

  localparam int P     = (HIDDEN_CNT + LANES - 1) / LANES;
  localparam int GW    = $clog2(P + 1);
  localparam int SUM_W = FEAT_BITS + 1 + $clog2(FEAT_CNT + 1);
  localparam int ACC_W = ((SUM_W > BIAS_BITS) ? SUM_W : BIAS_BITS) + 1;
  localparam int IDX_W = $clog2(HIDDEN_CNT + 1);

  // Per-neuron constant: bias plus the +1 corrections that turn each
  // ~{0,x} of a -1 weight into a true -x.
  function automatic logic [HIDDEN_CNT*ACC_W-1:0] build_corr();
    logic [HIDDEN_CNT*ACC_W-1:0] v;
    logic signed [BIAS_BITS-1:0] b;
    logic signed [ACC_W-1:0]     be;
    int                          neg;
    v = '0;
    for (int i = 0; i < HIDDEN_CNT; i++) begin
      neg = 0;
      for (int j = 0; j < FEAT_CNT; j++)
        if (!WEIGHTS[i*FEAT_CNT+j]) neg++;
      b  = BIASES[i*BIAS_BITS +: BIAS_BITS];
      be = b;
      v[i*ACC_W +: ACC_W] = be + ACC_W'(neg);
    end
    return v;
  endfunction

  localparam logic [HIDDEN_CNT*ACC_W-1:0] CORR = build_corr();

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 group_q, group_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q, feat_d;
  logic [HIDDEN_CNT-1:0]         hidden_q, hidden_d;

  logic [LANES-1:0]              lane_ok;
  logic [LANES-1:0]              lane_bit;
  logic [IDX_W-1:0]              lane_idx [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int                      idx;
    logic                    ok;
    logic [FEAT_CNT-1:0]     w;
    logic [FEAT_BITS-1:0]    x;
    logic signed [FEAT_BITS:0]   nx;
    logic signed [ACC_W-1:0] nx_ext;
    logic signed [ACC_W-1:0] acc;

    // Signed sum of one neuron of the current group; out-of-range lanes
    // are clamped to a legal index and then masked by ok.
    always_comb begin
      idx = int'(group_q) * LANES + l;
      ok  = (idx < HIDDEN_CNT);
      if (!ok) idx = HIDDEN_CNT - 1;
      w   = WEIGHTS[idx*FEAT_CNT +: FEAT_CNT];
      acc = CORR[idx*ACC_W +: ACC_W];
      x      = '0;
      nx     = '0;
      nx_ext = '0;
      for (int j = 0; j < FEAT_CNT; j++) begin
        x = feat_q[j*FEAT_BITS +: FEAT_BITS];
        if (w[j]) begin
          acc = acc + ACC_W'(x);
        end else begin
          nx     = ~{1'b0, x};
          nx_ext = nx;
          acc    = acc + nx_ext;
        end
      end
    end

    assign lane_ok[l]  = ok;
    assign lane_bit[l] = ~acc[ACC_W-1];
    assign lane_idx[l] = IDX_W'(idx);
  end

  // Next-state logic: accept start outside RUN, write one group per RUN cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path holds a stale value (no latch).
    state_d  = state_q;
    group_d  = group_q;
    feat_d   = feat_q;
    hidden_d = hidden_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          feat_d   = features;
          hidden_d = '0;
          group_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++)
          if (lane_ok[l]) hidden_d[lane_idx[l]] = lane_bit[l];
        group_d = group_q + 1'b1;
        if (group_q == GW'(P - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      group_q  <= '0;
      feat_q   <= '0;
      hidden_q <= '0;
    end else begin
      state_q  <= state_d;
      group_q  <= group_d;
      feat_q   <= feat_d;
      hidden_q <= hidden_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign hidden_valid = (state_q == DONE);
  assign hidden       = hidden_q;

endmodule
